imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction memory for the pipelined RISC-V core, sitting directly upstream of the core's instruction fetch port. It serves instruction words combinationally to the core's fetch address and is written by a byte-stream loader FSM. The loader receives a framed program image (sync byte, word count, payload, checksum) and holds the core in reset until a complete, valid image has been written.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit instruction words; must be a power of two.
- `ADDR_W`, default 10: word-index width; must equal log2(`DEPTH_WORDS`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  byte-stream valid.
- `rx_byte`  in  8  byte-stream data.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on an edge where `rx_valid & rx_ready`.
- `imem_addr`  in  32  byte address from core fetch (`top_imem_addr`).
- `imem_inst`  out  32  instruction word to core (`top_imem_inst`).
- `core_rst`  out  1  reset to the core; high while no valid image is present.
- `load_done`  out  1  valid image loaded.
- `load_err`  out  1  last load attempt failed.

## Operation
- Frame format: `0xA5`, `N[7:0]`, `N[15:8]`, then N words as 4 bytes each, least-significant byte first, then (with checksum enabled) one checksum byte. The checksum is the sum mod 256 of all 4·N payload bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: accepts and discards bytes until `0xA5` arrives, then goes to LEN_LO. Entering LEN_LO clears the word pointer, the byte counter and the checksum.
- LEN_LO → LEN_HI → evaluate N:
  - N > `DEPTH_WORDS` → ERR.
  - N = 0 → CSUM (or DONE when checksum is compiled out).
  - Otherwise → DATA.
- DATA: shifts each byte into a 32-bit assembly register and adds it to the checksum. After the 4th byte it goes to WRITE.
- WRITE: one cycle with `rx_ready`=0. Writes the assembled word to mem[pointer] and increments the pointer. If pointer+1 = N, go to CSUM (or DONE); otherwise return to DATA.
- CSUM: if the received byte equals the checksum → DONE, else → ERR.
- DONE: `0xA5` restarts a load (→ LEN_LO, `core_rst` back to 1, `load_done` to 0). Other bytes are discarded.
- ERR: `load_err`=1. `0xA5` restarts the load (→ LEN_LO, `load_err` cleared). Other bytes are discarded.
- Read port: `imem_inst` = mem[`imem_addr[ADDR_W+1:2]`]. The read is combinational; upper address bits are ignored, so addresses wrap. `imem_addr[1:0]` is ignored.
- While `core_rst`=1, `imem_inst` returns `0x00000013` (NOP) regardless of memory contents.
- Memory contents are not cleared by `rst`. Words not written by the current image keep their old values.

## Timing
- Reset values:
  - `rx_ready`=1 in the first cycle after reset.
  - `core_rst`=1, `load_done`=0, `load_err`=0, state IDLE.
- `rx_ready`=1 in every state except WRITE.
- A memory write occurs on the edge that leaves WRITE. The new word is visible on `imem_inst` in the following cycle.
- `core_rst` is registered. It falls on the same edge that enters DONE, and `load_done` rises on that edge.
- `load_err` rises on the edge that enters ERR.
- Gaps in `rx_valid` are allowed anywhere. State is held while no byte transfers.
- Reset mid-load returns to IDLE with `core_rst`=1. Words already written by the partial image remain in memory.
- Load latency for N words: 3 + 5·N + 1 accepted-byte/WRITE cycles minimum with the checksum enabled.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined: the frame carries a checksum byte, the CSUM state exists, and a mismatch goes to ERR.
- `IMEM_LOADER_CSUM_EN` undefined: there is no checksum byte and no CSUM state. The last WRITE (or N = 0 in LEN_HI) goes directly to DONE, and ERR is reachable only through an oversize N.

## Test plan
- Good load (checksum on): `A5 02 00 13 00 00 00 93 00 10 00` followed by the correct checksum `B6` → mem[0]=`0x00000013`, mem[1]=`0x00100093`, `core_rst` falls, `load_done`=1, `imem_inst`=`0x00100093` at `imem_addr`=4.
- Bad checksum: the same frame with checksum `B7` → ERR, `load_err`=1, `core_rst` stays 1, `imem_inst`=`0x00000013`.
- Oversize: `DEPTH_WORDS`=1024 with header `A5 01 04` (N=1025) → ERR after LEN_HI, and no memory write occurs.
- Noise and gaps: bytes `00 FF 5A` before `A5`, and random `rx_valid` gaps inside the payload → the bytes before `A5` are discarded and the result is identical to the good load. `rx_ready`=0 exactly one cycle after each 4th payload byte.
- Reset mid-load: assert `rst` after 2 payload bytes → IDLE, `core_rst`=1. A subsequent full good frame loads correctly.
- Reload: in DONE, send a new frame of one word `0x00000073` → `core_rst` rises on the `A5` edge and falls after the valid checksum; mem[0]=`0x00000073` and mem[1] is unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot instruction memory with a framed byte-stream loader that holds the core in reset.
// Latency: combinational fetch read; a word is readable the cycle after its WRITE; an N-word load takes >= 3+5N(+1 checksum) cycles.
// Backpressure: rx_ready drops for exactly one cycle (WRITE) after every 4th payload byte; otherwise always ready.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   rx_valid/rx_byte     byte stream in; rx_ready out (transfer on rx_valid & rx_ready)
//   imem_addr/imem_inst  byte-address fetch port, combinational word read (NOP while core_rst)
//   core_rst             core reset, high until a valid image is resident
//   load_done/load_err   last load completed / failed
// Frame: 0xA5, N[7:0], N[15:8], N words LSB-first, [checksum byte].
// Build option: define IMEM_LOADER_CSUM_EN to carry and verify the trailing checksum byte.

module imem_loader #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        rx_ready,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_inst,
   output logic        core_rst,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [7:0]  SYNC = 8'hA5;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM   = 3'd5,
`endif
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ptr_q, ptr_d;      // wide enough to compare against N up to 0xFFFF
   logic [15:0] len_q, len_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] word_q, word_d;
   logic        rx_ready_q, rx_ready_d;
   logic        core_rst_q, core_rst_d;
   logic        load_done_q, load_done_d;
   logic        load_err_q, load_err_d;

   logic        xfer;
   logic        mem_we;
   logic [15:0] n_len;

   logic [31:0] mem [DEPTH_WORDS];

   // Only the word-index bits of the fetch address matter; the rest wrap/ignore.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{imem_addr[31:ADDR_W+2], imem_addr[1:0]};

   assign xfer  = rx_valid & rx_ready_q;
   assign n_len = {rx_byte, len_q[7:0]};

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      word_d      = word_q;
      core_rst_d  = core_rst_q;
      load_done_d = load_done_q;
      load_err_d  = load_err_q;
      mem_we      = 1'b0;

      case (state_q)
         // A sync byte (re)starts a load from any resting state; the core goes
         // back into reset immediately so it never runs a half-written image.
         S_IDLE, S_DONE, S_ERR: begin
            if (xfer && rx_byte == SYNC) begin
               state_d     = S_LEN_LO;
               ptr_d       = '0;
               cnt_d       = '0;
               csum_d      = '0;
               core_rst_d  = 1'b1;
               load_done_d = 1'b0;
               load_err_d  = 1'b0;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = rx_byte;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = n_len;
               if (32'(n_len) > DEPTH_WORDS) begin
                  state_d    = S_ERR;
                  load_err_d = 1'b1;
               end else if (n_len == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                  state_d = S_CSUM;
`else
                  state_d     = S_DONE;
                  core_rst_d  = 1'b0;
                  load_done_d = 1'b1;
`endif
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               // LSB arrives first, so shift in from the top.
               word_d = {rx_byte, word_q[31:8]};
               csum_d = csum_q + rx_byte;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + 16'd1;
            if (ptr_q + 16'd1 == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
               state_d = S_CSUM;
`else
               state_d     = S_DONE;
               core_rst_d  = 1'b0;
               load_done_d = 1'b1;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         S_CSUM: begin
            if (xfer) begin
               if (rx_byte == csum_q) begin
                  state_d     = S_DONE;
                  core_rst_d  = 1'b0;
                  load_done_d = 1'b1;
               end else begin
                  state_d    = S_ERR;
                  load_err_d = 1'b1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Ready is registered from the next state so it is low exactly in WRITE.
      rx_ready_d = (state_d != S_WRITE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         word_q      <= '0;
         rx_ready_q  <= 1'b1;
         core_rst_q  <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         word_q      <= word_d;
         rx_ready_q  <= rx_ready_d;
         core_rst_q  <= core_rst_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   // Memory is deliberately not reset: a partial or failed load leaves
   // whatever was written, and untouched words keep older contents.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[ptr_q[ADDR_W-1:0]] <= word_q;
      end
   end

   assign imem_inst = core_rst_q ? NOP : mem[imem_addr[ADDR_W+1:2]];
   assign rx_ready  = rx_ready_q;
   assign core_rst  = core_rst_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames plus randomized frames/gaps,
// checked against a frame-level reference model of memory and load status.
module tb_imem_loader;

   localparam int          DEPTH = 1024;
   localparam int          AW    = 10;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_LOADER_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        rx_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        core_rst;
   logic        load_done;
   logic        load_err;

   imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .rx_ready  (rx_ready),
      .imem_addr (imem_addr),
      .imem_inst (imem_inst),
      .core_rst  (core_rst),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [31:0] ref_mem [DEPTH];
   bit          ref_vld [DEPTH];
   bit          exp_done;
   bit          exp_err;

   logic [31:0] words_q [$];
   logic [7:0]  frame_q [$];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change at posedge+1; every call returns at posedge+1.
   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int guard = 0;
      repeat ($urandom_range(gap_max)) begin
         rx_valid = 1'b0;
         @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_byte  = b;
      while (rx_ready !== 1'b1 && guard < 16) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 16) chk1("rx_ready_timeout", rx_ready, 1'b1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic build_frame(input int n_field, input bit bad_csum);
      logic [7:0] sum = 8'h00;
      logic [7:0] b;
      frame_q = {};
      frame_q.push_back(8'hA5);
      frame_q.push_back(n_field[7:0]);
      frame_q.push_back(n_field[15:8]);
      foreach (words_q[w]) begin
         for (int k = 0; k < 4; k++) begin
            b = words_q[w][8*k +: 8];
            frame_q.push_back(b);
            sum = sum + b;
         end
      end
      if (CSUM_EN && n_field <= DEPTH) frame_q.push_back(bad_csum ? sum + 8'h01 : sum);
   endtask

   // Frame-level outcome: oversize -> error, no writes; otherwise all words
   // land in memory, and the checksum decides done vs error.
   task automatic model_frame(input int n_field, input bit bad_csum);
      if (n_field > DEPTH) begin
         exp_err  = 1'b1;
         exp_done = 1'b0;
      end else begin
         foreach (words_q[w]) begin
            ref_mem[w] = words_q[w];
            ref_vld[w] = 1'b1;
         end
         exp_err  = CSUM_EN && bad_csum;
         exp_done = !exp_err;
      end
   endtask

   task automatic send_frame(input int gap_max);
      int nw = words_q.size();
      for (int i = 0; i < frame_q.size(); i++) begin
         send_byte(frame_q[i], gap_max);
         if (i == 0) begin
            chk1("sync_core_rst", core_rst, 1'b1);
            chk1("sync_load_done", load_done, 1'b0);
            chk1("sync_load_err", load_err, 1'b0);
         end
         if (i >= 3 && i < 3 + 4*nw && ((i - 3) % 4) == 3) begin
            chk1("write_rdy_low", rx_ready, 1'b0);
            @(posedge clk); #1;
            chk1("write_rdy_back", rx_ready, 1'b1);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] hi;
      chk1({tag, "_core_rst"}, core_rst, !exp_done);
      chk1({tag, "_load_done"}, load_done, exp_done);
      chk1({tag, "_load_err"}, load_err, exp_err);
      chk1({tag, "_rx_ready"}, rx_ready, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (ref_vld[i]) begin
            hi = $urandom;
            hi[AW+1:0] = '0;
            imem_addr = hi | (32'(i) << 2) | 32'($urandom_range(3));
            #1;
            chk32({tag, "_inst"}, imem_inst, exp_done ? ref_mem[i] : NOP);
         end
      end
      imem_addr = 32'd4;
      #1;
      chk32({tag, "_inst_a4"}, imem_inst, exp_done ? ref_mem[1] : NOP);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] nb;
      int         n;
      bit         bad;

      foreach (ref_vld[i]) ref_vld[i] = 1'b0;
      rst       = 1'b1;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      imem_addr = 32'h0;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk1("rst_rx_ready", rx_ready, 1'b1);
      chk1("rst_core_rst", core_rst, 1'b1);
      chk1("rst_load_done", load_done, 1'b0);
      chk1("rst_load_err", load_err, 1'b0);
      chk32("rst_inst", imem_inst, NOP);

      // Good two-word load
      words_q = {32'h0000_0013, 32'h0010_0093};
      build_frame(2, 1'b0);
      model_frame(2, 1'b0);
      send_frame(0);
      check_outputs("good");

      // Bad checksum (loads normally when the checksum is compiled out)
      build_frame(2, 1'b1);
      model_frame(2, 1'b1);
      send_frame(0);
      check_outputs("badcsum");

      // Oversize header: ERR, nothing written
      words_q = {};
      build_frame(DEPTH + 1, 1'b0);
      model_frame(DEPTH + 1, 1'b0);
      send_frame(0);
      check_outputs("oversize");

      // Noise before sync, gaps inside the payload
      send_byte(8'h00, 2);
      send_byte(8'hFF, 2);
      send_byte(8'h5A, 2);
      words_q = {32'h0000_0013, 32'h0010_0093};
      build_frame(2, 1'b0);
      model_frame(2, 1'b0);
      send_frame(3);
      check_outputs("noise");

      // Reset after two payload bytes
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      check_outputs("midrst");
      build_frame(2, 1'b0);
      model_frame(2, 1'b0);
      send_frame(1);
      check_outputs("after_rst");

      // Reload one word from DONE; word 1 must be untouched
      words_q = {32'h0000_0073};
      build_frame(1, 1'b0);
      model_frame(1, 1'b0);
      send_frame(0);
      check_outputs("reload");

      // Empty image
      words_q = {};
      build_frame(0, 1'b0);
      model_frame(0, 1'b0);
      send_frame(0);
      check_outputs("empty");

      // Randomized frames with noise and gaps
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(3)) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h00;
            send_byte(nb, 2);
         end
         n   = $urandom_range(1, 8);
         bad = ($urandom_range(3) == 0);
         words_q = {};
         repeat (n) words_q.push_back($urandom);
         build_frame(n, bad);
         model_frame(n, bad);
         send_frame(2);
         check_outputs("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
